// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters sharing one DW-bit valid/ready channel.
// Each grant is released after HOLD_MAX accepted beats or when its requester withdraws.
module rr_mux_arbiter #(
   parameter int DW       = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] in1,
   input  logic [DW-1:0] in2,
   input  logic [DW-1:0] in3,
   input  logic [DW-1:0] in4,
   input  logic          out_ready,
   output logic [3:0]    gnt,
   output logic [1:0]    addr,
   output logic [DW-1:0] Mout,
   output logic          out_valid,
   output logic          busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);

   state_t        state;
   logic [1:0]    ptr;
   logic [3:0]    beat_cnt;

   logic [1:0]    win;
   logic          win_found;
   logic [1:0]    cand;
   logic [DW-1:0] sel_data;
   logic          accept;
   logic          last_beat;

   // Search starts one past the last granted source, so the previous owner is checked last.
   // NOTE: every always_comb output gets a default first; otherwise a path that
   // skips an assignment infers a latch.
   always_comb begin
      win       = ptr;
      win_found = 1'b0;
      cand      = ptr;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr + 2'(k);
         if (!win_found && req[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = in1;
      case (addr)
         2'd0: sel_data = in1;
         2'd1: sel_data = in2;
         2'd2: sel_data = in3;
         2'd3: sel_data = in4;
         default: sel_data = in1;
      endcase
   end

   assign busy      = (state == GRANT);
   assign out_valid = busy && req[addr];
   assign Mout      = out_valid ? sel_data : '0;
   assign accept    = out_valid && out_ready;
   assign last_beat = (beat_cnt == LAST_BEAT);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         addr     <= 2'b00;
         ptr      <= 2'd3;
         beat_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  gnt      <= 4'b0001 << win;
                  addr     <= win;
                  beat_cnt <= 4'd0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // A withdrawn request releases at once; no beat can be accepted that cycle.
               if (!req[addr] || (accept && last_beat)) begin
                  ptr      <= addr;
                  gnt      <= 4'b0000;
                  beat_cnt <= 4'd0;
                  state    <= IDLE;
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 4'b0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the arbitration rules.
module tb_rr_mux_arbiter;

   localparam int DW       = 4;
   localparam int HOLD_MAX = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    req = 4'b0000;
   logic [DW-1:0] in1 = '0;
   logic [DW-1:0] in2 = '0;
   logic [DW-1:0] in3 = '0;
   logic [DW-1:0] in4 = '0;
   logic          out_ready = 1'b0;
   logic [3:0]    gnt;
   logic [1:0]    addr;
   logic [DW-1:0] Mout;
   logic          out_valid;
   logic          busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in4       (in4),
      .out_ready (out_ready),
      .gnt       (gnt),
      .addr      (addr),
      .Mout      (Mout),
      .out_valid (out_valid),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the channel, who owned it last, beats served so far.
   bit m_on    = 1'b0;
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_last  = 3;
   int m_beats = 0;

   function automatic logic [DW-1:0] src_data(input int i);
      case (i)
         0: return in1;
         1: return in2;
         2: return in3;
         default: return in4;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_on    = 1'b1;
         m_busy  = 1'b0;
         m_owner = 0;
         m_last  = 3;
         m_beats = 0;
      end else if (m_on) begin
         if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
               if (!m_busy && req[(m_last + k) % 4]) begin
                  m_busy  = 1'b1;
                  m_owner = (m_last + k) % 4;
                  m_beats = 0;
               end
            end
         end else if (!req[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
         end else if (out_ready) begin
            m_beats++;
            if (m_beats == HOLD_MAX) begin
               m_busy  = 1'b0;
               m_last  = m_owner;
               m_beats = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (m_on) begin
         check("gnt", gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
         check("addr", addr, m_owner);
         check("busy", busy, m_busy);
         check("out_valid", out_valid, m_busy && req[m_owner]);
         check("Mout", Mout, (m_busy && req[m_owner]) ? src_data(m_owner) : '0);
      end
   end

   task automatic cyc();
      @(negedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   int order[$];
   int runs[$];
   int exp_order[5] = '{0, 1, 2, 3, 0};
   int run;
   int n;
   bit prev;

   initial begin
      // Reset state
      rst = 1'b1;
      cyc();
      cyc();
      check("rst_gnt", gnt, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_mout", Mout, 4'h0);
      check("rst_addr", addr, 2'b00);

      // Single requester, four beats, then release
      rst = 1'b0; req = 4'b0100; in3 = 4'hA; out_ready = 1'b1;
      cyc();
      check("s1_gnt", gnt, 4'b0100);
      check("s1_addr", addr, 2'd2);
      check("s1_mout", Mout, 4'hA);
      check("s1_valid", out_valid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("s1_hold", busy, 1'b1);
      end
      cyc();
      check("s1_release", busy, 1'b0);
      req = 4'b0000;

      // All requesting: fair rotation from reset, 4 beats each, one idle gap
      rst = 1'b1;
      cyc();
      rst = 1'b0; req = 4'b1111;
      run = 0; prev = 1'b0; n = 0;
      while (runs.size() < 5 && n < 80) begin
         cyc();
         n++;
         if (busy && !prev) order.push_back(int'(addr));
         if (busy) run++;
         if (!busy && prev) begin
            runs.push_back(run);
            run = 0;
         end
         prev = busy;
      end
      check("s2_grants", runs.size(), 5);
      for (int i = 0; i < 5 && i < order.size(); i++) check("s2_order", order[i], exp_order[i]);
      for (int i = 0; i < runs.size(); i++) check("s2_len", runs[i], HOLD_MAX);

      // Backpressure on source 1: grant held, Mout follows live data
      req = 4'b0010; in2 = 4'h5; out_ready = 1'b0;
      cyc();
      check("s3_gnt", gnt, 4'b0010);
      for (int i = 0; i < 10; i++) begin
         if (i == 5) in2 = 4'h6;
         cyc();
         check("s3_hold", gnt, 4'b0010);
         check("s3_mout", Mout, (i >= 5) ? 4'h6 : 4'h5);
      end
      out_ready = 1'b1;
      n = 0;
      do begin
         cyc();
         n++;
      end while (busy && n < 10);
      check("s3_beats", n, HOLD_MAX);

      // Source 2 withdraws after two beats; next grant goes to source 0
      req = 4'b0101; in3 = 4'hC; in1 = 4'h3;
      cyc();
      check("s4_gnt", gnt, 4'b0100);
      cyc();
      cyc();
      req = 4'b0001;
      #1;
      check("s4_valid_drop", out_valid, 1'b0);
      check("s4_mout_drop", Mout, 4'h0);
      cyc();
      check("s4_release", busy, 1'b0);
      cyc();
      check("s4_next_gnt", gnt, 4'b0001);
      check("s4_next_addr", addr, 2'd0);

      // Reset in the middle of a grant
      cyc();
      rst = 1'b1;
      cyc();
      check("s5_gnt", gnt, 4'b0000);
      check("s5_valid", out_valid, 1'b0);
      check("s5_mout", Mout, 4'h0);
      rst = 1'b0; req = 4'b1001;
      cyc();
      check("s5_first", gnt, 4'b0001);

      // No requests for 20 cycles
      rst = 1'b1; req = 4'b0000;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         check("s6_gnt", gnt, 4'b0000);
         check("s6_busy", busy, 1'b0);
      end

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in1 = DW'($urandom);
         in2 = DW'($urandom);
         in3 = DW'($urandom);
         in4 = DW'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
